// File: rtl/crop_pkg.sv
// crop_pkg: shared defaults, widths, max-origin constants and FSM state type for crop_ctrl.
package crop_pkg;
  localparam int PIXEL_BIT_WIDTH_D = 10;
  localparam int IN_ROWS_D = 20;
  localparam int IN_COLS_D = 20;
  localparam int OUT_ROWS_D = 10;
  localparam int OUT_COLS_D = 10;
  localparam int COL_W = $clog2(IN_COLS_D);
  localparam int ROW_W = $clog2(IN_ROWS_D);
  localparam int MAX_X0 = IN_COLS_D - OUT_COLS_D;
  localparam int MAX_Y0 = IN_ROWS_D - OUT_ROWS_D;
  typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/crop_if.sv
// crop_if: host control and crop-origin configuration handshake of crop_ctrl.
interface crop_if #(parameter int COL_W = crop_pkg::COL_W, parameter int ROW_W = crop_pkg::ROW_W);
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic cfg_wr;
  logic [COL_W-1:0] cfg_x0;
  logic [ROW_W-1:0] cfg_y0;
  logic cfg_err;
  modport master(output ap_start, cfg_wr, cfg_x0, cfg_y0, input ap_ready, ap_done, cfg_err);
  modport slave(input ap_start, cfg_wr, cfg_x0, cfg_y0, output ap_ready, ap_done, cfg_err);
endinterface

// File: rtl/pixel_coord_counter.sv
// pixel_coord_counter: column/row position of the current stream beat, with last-beat pulse.
module pixel_coord_counter #(
  parameter int IN_COLS = 20,
  parameter int IN_ROWS = 20,
  localparam int CW = $clog2(IN_COLS),
  localparam int RW = $clog2(IN_ROWS)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          beat,
  output logic [CW-1:0] cnt_col,
  output logic [RW-1:0] cnt_row,
  output logic          frame_end
);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic last_col, last_row;
  always_comb begin
    last_col = col_q == CW'(IN_COLS - 1);
    last_row = row_q == RW'(IN_ROWS - 1);
    col_d = beat ? (last_col ? '0 : col_q + 1'b1) : col_q;
    row_d = (beat && last_col) ? (last_row ? '0 : row_q + 1'b1) : row_q;
    frame_end = beat && last_col && last_row;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  assign cnt_col = col_q;
  assign cnt_row = row_q;
endmodule

// File: rtl/crop_ctrl.sv
// crop_ctrl: frame sequencer for a crop filter; latches a validated crop origin per frame and tracks beat position.
module crop_ctrl import crop_pkg::*; #(
  parameter int PIXEL_BIT_WIDTH = PIXEL_BIT_WIDTH_D,
  parameter int IN_ROWS = IN_ROWS_D,
  parameter int IN_COLS = IN_COLS_D,
  parameter int OUT_ROWS = OUT_ROWS_D,
  parameter int OUT_COLS = OUT_COLS_D,
  localparam int CW = $clog2(IN_COLS),
  localparam int RW = $clog2(IN_ROWS)
)(
  input  logic          clk,
  input  logic          s_axis_resetn,
  crop_if.slave         host,
  output logic          cf_ap_start,
  output logic [CW-1:0] crop_x0,
  output logic [RW-1:0] crop_y0,
  input  logic          nr_ap_ready,
  input  logic          max_value_tvalid,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tready,
  output logic          stream_en,
  output logic [CW-1:0] cnt_col,
  output logic [RW-1:0] cnt_row,
  output logic          frame_end
);
  localparam logic [CW:0] MAX_X = (CW+1)'(IN_COLS - OUT_COLS);
  localparam logic [RW:0] MAX_Y = (RW+1)'(IN_ROWS - OUT_ROWS);
  if (PIXEL_BIT_WIDTH < 1 || OUT_COLS > IN_COLS || OUT_ROWS > IN_ROWS) begin : g_bad_params
    $error("crop_ctrl: crop window does not fit the input frame");
  end
  state_t state_q, state_d;
  logic [CW-1:0] sx_q, sx_d, cx_q, cx_d;
  logic [RW-1:0] sy_q, sy_d, cy_q, cy_d;
  logic cf_start_q, cf_start_d, stream_en_q, stream_en_d, done_q, done_d, err_q, err_d;
  logic beat, cfg_ok;
  assign beat = s_axis_tvalid && s_axis_tready && stream_en_q;
  pixel_coord_counter #(.IN_COLS(IN_COLS), .IN_ROWS(IN_ROWS)) u_cnt (
    .clk(clk), .rst_n(s_axis_resetn), .beat(beat),
    .cnt_col(cnt_col), .cnt_row(cnt_row), .frame_end(frame_end)
  );
  // Active origin copies the shadow before this cycle's write lands, so a same-cycle cfg_wr waits a frame.
  always_comb begin
    state_d = state_q;
    cx_d = cx_q;
    cy_d = cy_q;
    case (state_q)
      IDLE: if (host.ap_start && nr_ap_ready) begin
        state_d = START;
        cx_d = sx_q;
        cy_d = sy_q;
      end
      START: state_d = RUN;
      RUN: state_d = frame_end ? DRAIN : RUN;
      DRAIN: state_d = max_value_tvalid ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
    cfg_ok = ({1'b0, host.cfg_x0} <= MAX_X) && ({1'b0, host.cfg_y0} <= MAX_Y);
    sx_d = (host.cfg_wr && cfg_ok) ? host.cfg_x0 : sx_q;
    sy_d = (host.cfg_wr && cfg_ok) ? host.cfg_y0 : sy_q;
    err_d = host.cfg_wr && !cfg_ok;
    cf_start_d = state_d == START;
    stream_en_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge s_axis_resetn)
    if (!s_axis_resetn) begin
      state_q <= IDLE;
      sx_q <= '0;
      sy_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      cf_start_q <= 1'b0;
      stream_en_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      cf_start_q <= cf_start_d;
      stream_en_q <= stream_en_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign host.ap_ready = (state_q == IDLE) && nr_ap_ready;
  assign host.ap_done = done_q;
  assign host.cfg_err = err_q;
  assign cf_ap_start = cf_start_q;
  assign stream_en = stream_en_q;
  assign crop_x0 = cx_q;
  assign crop_y0 = cy_q;
endmodule

// File: tb/tb_crop_ctrl.sv
// tb_crop_ctrl: table vectors, directed corner sequences and random traffic against a beat-count reference model.
module tb_crop_ctrl;
  localparam int IC = 20, IR = 20, NB = IC * IR;
  logic clk = 1'b0, rst_n = 1'b0;
  logic nr = 1'b0, tvalid = 1'b0, tready = 1'b0, mv = 1'b0;
  logic cf_ap_start, stream_en, frame_end;
  logic [4:0] crop_x0, crop_y0, cnt_col, cnt_row;
  int n_tests = 0, n_fail = 0;
  int ph = 0, beats = 0, sx = 0, sy = 0, cx = 0, cy = 0, err = 0;
  typedef struct {int x; int y; int e; int ex; int ey;} vec_t;
  vec_t tab[7];
  crop_if #(.COL_W(5), .ROW_W(5)) h();
  crop_ctrl dut (
    .clk(clk), .s_axis_resetn(rst_n), .host(h), .cf_ap_start(cf_ap_start),
    .crop_x0(crop_x0), .crop_y0(crop_y0), .nr_ap_ready(nr), .max_value_tvalid(mv),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .stream_en(stream_en),
    .cnt_col(cnt_col), .cnt_row(cnt_row), .frame_end(frame_end)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at %0t: got %0d, expected %0d", n, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    ph = 0; beats = 0; sx = 0; sy = 0; cx = 0; cy = 0; err = 0;
  endtask
  // ph: 0 idle, 1 start, 2 run, 3 drain, 4 done; beats = beats accepted so far in this frame
  task automatic cycle();
    int b;
    #1;
    b = int'(ph == 2 && tvalid && tready);
    chk("ap_ready", h.ap_ready, int'(ph == 0 && nr));
    chk("cf_ap_start", cf_ap_start, int'(ph == 1));
    chk("stream_en", stream_en, int'(ph == 2));
    chk("ap_done", h.ap_done, int'(ph == 4));
    chk("cfg_err", h.cfg_err, err);
    chk("cnt_col", cnt_col, beats % IC);
    chk("cnt_row", cnt_row, beats / IC);
    chk("frame_end", frame_end, int'(b == 1 && beats == NB - 1));
    chk("crop_x0", crop_x0, cx);
    chk("crop_y0", crop_y0, cy);
    if (!rst_n) model_reset();
    else begin
      case (ph)
        0: if (h.ap_start && nr) begin ph = 1; cx = sx; cy = sy; end
        1: ph = 2;
        2: if (b == 1) begin beats = (beats + 1) % NB; if (beats == 0) ph = 3; end
        3: if (mv) ph = 4;
        default: ph = 0;
      endcase
      err = 0;
      if (h.cfg_wr) begin
        if (int'(h.cfg_x0) <= IC - 10 && int'(h.cfg_y0) <= IR - 10) begin sx = h.cfg_x0; sy = h.cfg_y0; end
        else err = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic start_frame();
    nr = 1'b1; h.ap_start = 1'b1;
    cycle();
    h.ap_start = 1'b0;
  endtask
  task automatic run_until_beats(input int n);
    tvalid = 1'b1; tready = 1'b1;
    for (int i = 0; i < 2000 && !(ph == 2 && beats == n); i++) cycle();
    chk("beat_reach", beats, n);
  endtask
  task automatic finish_frame(input bit rnd);
    for (int i = 0; i < 5000 && ph != 0; i++) begin
      tvalid = rnd ? ($urandom % 4 != 0) : 1'b1;
      tready = rnd ? ($urandom % 4 != 0) : 1'b1;
      mv = rnd ? ($urandom % 3 == 0) : 1'b1;
      cycle();
    end
    chk("frame_bound", int'(ph == 0), 1);
    tvalid = 1'b0; tready = 1'b0;
  endtask
  task automatic write_cfg(input int x, input int y);
    h.cfg_wr = 1'b1; h.cfg_x0 = 5'(x); h.cfg_y0 = 5'(y);
    cycle();
    h.cfg_wr = 1'b0;
  endtask
  initial begin
    tab[0] = '{5, 3, 0, 5, 3};
    tab[1] = '{11, 0, 1, 5, 3};
    tab[2] = '{0, 11, 1, 5, 3};
    tab[3] = '{10, 10, 0, 10, 10};
    tab[4] = '{31, 31, 1, 10, 10};
    tab[5] = '{0, 0, 0, 0, 0};
    tab[6] = '{10, 11, 1, 0, 0};
    h.ap_start = 1'b0; h.cfg_wr = 1'b0; h.cfg_x0 = '0; h.cfg_y0 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst_n = 1'b1;
    cycle();
    for (int i = 0; i < 7; i++) begin
      write_cfg(tab[i].x, tab[i].y);
      chk("tab_cfg_err", h.cfg_err, tab[i].e);
      start_frame();
      chk("tab_crop_x0", crop_x0, tab[i].ex);
      chk("tab_crop_y0", crop_y0, tab[i].ey);
      finish_frame(1'b0);
    end
    // origin written mid-frame must wait for the next frame
    write_cfg(5, 3);
    start_frame();
    run_until_beats(50);
    write_cfg(2, 3);
    for (int i = 0; i < 2000 && ph != 4; i++) cycle();
    chk("midcfg_done", h.ap_done, 1);
    chk("midcfg_hold_x0", crop_x0, 5);
    cycle();
    start_frame();
    chk("midcfg_next_x0", crop_x0, 2);
    run_until_beats(123);
    tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk("bp_row", cnt_row, 6);
      chk("bp_col", cnt_col, 3);
      chk("bp_frame_end", frame_end, 0);
    end
    mv = 1'b0;
    finish_frame(1'b0);
    // same-cycle write and start: active origin takes the old shadow
    nr = 1'b1; h.ap_start = 1'b1; h.cfg_wr = 1'b1; h.cfg_x0 = 5'd7; h.cfg_y0 = 5'd1;
    cycle();
    h.ap_start = 1'b0; h.cfg_wr = 1'b0;
    chk("same_cycle_x0", crop_x0, 2);
    chk("same_cycle_y0", crop_y0, 3);
    run_until_beats(150);
    rst_n = 1'b0;
    #1;
    chk("rst_cnt_col", cnt_col, 0);
    chk("rst_cnt_row", cnt_row, 0);
    chk("rst_stream_en", stream_en, 0);
    chk("rst_crop_x0", crop_x0, 0);
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    nr = 1'b0; h.ap_start = 1'b1;
    repeat (5) cycle();
    chk("nr_low_ready", h.ap_ready, 0);
    chk("nr_low_start", cf_ap_start, 0);
    nr = 1'b1;
    cycle();
    h.ap_start = 1'b0;
    chk("nr_rise_start", cf_ap_start, 1);
    cycle();
    chk("nr_single_pulse", cf_ap_start, 0);
    finish_frame(1'b1);
    for (int i = 0; i < 8000; i++) begin
      h.ap_start = ($urandom % 8 == 0);
      nr = ($urandom % 4 != 0);
      tvalid = ($urandom % 4 != 0);
      tready = ($urandom % 4 != 0);
      mv = ($urandom % 3 == 0);
      h.cfg_wr = ($urandom % 25 == 0);
      h.cfg_x0 = 5'($urandom % 16);
      h.cfg_y0 = 5'($urandom % 16);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
